// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            edge_count_q, edge_count_d;
  logic [4:0]            prescale_m1_q, prescale_m1_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
`endif

  logic [4:0]       prescale_m1_in;
  logic             bit_done;
  logic             last_data_bit;
  logic [IDX_W-1:0] next_idx;
  logic             load_frame;

  // Only 8 and 16 are honoured as-is; every other setting runs at 32 clocks per bit.
  always_comb begin
    case (Prescale)
      6'd8:    prescale_m1_in = 5'd7;
      6'd16:   prescale_m1_in = 5'd15;
      default: prescale_m1_in = 5'd31;
    endcase
  end

  assign bit_done      = (edge_count_q == prescale_m1_q);
  assign last_data_bit = (bit_idx_q == IDX_W'(DATA_WIDTH - 1));
  assign next_idx      = bit_idx_q + IDX_W'(1);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    prescale_m1_d = prescale_m1_q;
    bit_idx_d     = bit_idx_q;
    data_d        = data_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
`endif
    load_frame    = 1'b0;

    edge_count_d = (state_q == IDLE || bit_done) ? 5'd0 : edge_count_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (Data_Valid) load_frame = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (!last_data_bit) begin
            bit_idx_d = next_idx;
            tx_d      = data_q[next_idx];
          end else begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        // A request landing on the final stop edge chains the next frame with no idle gap.
        if (bit_done) begin
          if (Data_Valid) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load_frame) begin
      state_d       = START;
      data_d        = P_DATA;
      prescale_m1_d = prescale_m1_in;
      edge_count_d  = 5'd0;
      bit_idx_d     = '0;
      tx_d          = 1'b0;
      busy_d        = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d      = PAR_EN;
      par_typ_d     = PAR_TYP;
`endif
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      edge_count_q  <= 5'd0;
      prescale_m1_q <= 5'd0;
      bit_idx_q     <= '0;
      data_q        <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      edge_count_q  <= edge_count_d;
      prescale_m1_q <= prescale_m1_d;
      bit_idx_q     <= bit_idx_d;
      data_q        <= data_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule
